// File: rtl/boot_pkg.sv
// Shared definitions for the instruction-memory boot controller.
//
// Contents:
//   HDR_BYTES     number of bytes in the word-count header
//   HDR_BITS      width of the word count assembled from the header
//   boot_state_t  controller FSM state encoding
//   header_count  joins the two little-endian header bytes into a count
package boot_pkg;

    localparam int HDR_BYTES = 2;
    localparam int HDR_BITS  = 8 * HDR_BYTES;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_HDR_LO = 3'd1,
        ST_HDR_HI = 3'd2,
        ST_LOAD   = 3'd3,
        ST_RUN    = 3'd4,
        ST_DONE   = 3'd5,
        ST_ERROR  = 3'd6
    } boot_state_t;

    // The header arrives low byte first.
    function automatic logic [HDR_BITS-1:0] header_count(input logic [7:0] lo,
                                                         input logic [7:0] hi);
        return {hi, lo};
    endfunction

endpackage

// File: rtl/imem_boot_ctrl_byte_packer.sv
// Byte-to-word assembler for the boot loader.
//
// Collects four accepted bytes into one 32-bit word, little-endian (the first
// byte lands in bits 7:0). The cycle after the fourth byte is accepted,
// word_valid pulses high for one cycle with the completed word on 'word'.
// 'word' holds its value until the next word completes, so bytes of the
// following word may already be accepted during the word_valid cycle.
//
// Ports:
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   clear      synchronous clear of the byte counter and partial word
//   byte_en    a byte is accepted this cycle
//   byte_data  accepted byte
//   word_valid one-cycle pulse: 'word' holds a newly completed word
//   word       last completed 32-bit word
module byte_packer
    import boot_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        byte_en,
    input  logic [7:0]  byte_data,
    output logic        word_valid,
    output logic [31:0] word
);

    logic [1:0]  byte_cnt;
    logic [23:0] partial;

    // The first three bytes shift in from the top so that, when the fourth
    // byte arrives, {byte, partial} is already in little-endian order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_cnt   <= 2'd0;
            partial    <= 24'd0;
            word       <= 32'd0;
            word_valid <= 1'b0;
        end else if (clear) begin
            byte_cnt   <= 2'd0;
            partial    <= 24'd0;
            word_valid <= 1'b0;
        end else begin
            word_valid <= 1'b0;
            if (byte_en) begin
                if (byte_cnt == 2'd3) begin
                    word       <= {byte_data, partial};
                    word_valid <= 1'b1;
                end else begin
                    partial <= {byte_data, partial[23:8]};
                end
                byte_cnt <= byte_cnt + 2'd1;
            end
        end
    end

endmodule

// File: rtl/imem_boot_ctrl.sv
// Instruction-memory boot controller.
//
// On 'start' it reads a two-byte little-endian word count N from the byte
// stream, then N little-endian 32-bit words which are written to consecutive
// instruction-memory addresses starting at 0. It then releases the core from
// reset for RUN_CYCLES cycles and reports DONE. A count larger than the
// memory capacity sends it to ERROR without writing anything.
//
// Parameters:
//   ADDR_WIDTH  instruction-memory word-address width (2^ADDR_WIDTH words)
//   SIZE        instruction word width (32)
//   RUN_CYCLES  core cycles granted per run
//
// Ports:
//   CLK         clock, rising edge
//   RESET_N     asynchronous active-low reset
//   start       request a load-and-run sequence (from IDLE, DONE or ERROR)
//   abort       synchronous return to IDLE, highest priority
//   rx_valid    byte-stream valid
//   rx_data     byte-stream payload
//   rx_ready    byte accepted when rx_valid && rx_ready
//   iwr_en      instruction-memory write strobe
//   iwr_addr    instruction-memory word address
//   iwr_data    instruction word
//   core_rst_n  active-low reset to the core, released only while running
//   busy        sequence in progress (header, load or run)
//   done        run completed
//   error       header word count exceeded memory capacity
module imem_boot_ctrl
    import boot_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int SIZE       = 32,
    parameter int RUN_CYCLES = 1000
) (
    input  logic                  CLK,
    input  logic                  RESET_N,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  rx_valid,
    input  logic [7:0]            rx_data,
    output logic                  rx_ready,
    output logic                  iwr_en,
    output logic [ADDR_WIDTH-1:0] iwr_addr,
    output logic [SIZE-1:0]       iwr_data,
    output logic                  core_rst_n,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    // Capacity and counts are compared at 33 bits so that neither the 16-bit
    // header count nor 2^ADDR_WIDTH can overflow the comparison.
    localparam logic [32:0] CAPACITY = 33'(1) << ADDR_WIDTH;
    localparam logic [31:0] RUN_LAST = (RUN_CYCLES > 0) ? 32'(RUN_CYCLES - 1) : 32'd0;

    boot_state_t           state;
    boot_state_t           next_state;
    logic [7:0]            hdr_lo;
    logic [HDR_BITS-1:0]   word_count;
    logic [HDR_BITS-1:0]   hdr_words;
    logic [ADDR_WIDTH-1:0] word_idx;
    logic [31:0]           run_cnt;
    logic                  accept;
    logic                  last_word;
    logic                  pack_clear;
    logic                  pack_en;
    logic                  word_valid;
    logic [31:0]           packed_word;

    assign rx_ready  = (state == ST_HDR_LO) || (state == ST_HDR_HI) || (state == ST_LOAD);
    assign accept    = rx_valid && rx_ready;
    assign hdr_words = header_count(hdr_lo, rx_data);
    assign last_word = (33'(word_idx) + 33'd1) == 33'(word_count);

    // The packer only runs in LOAD; outside it, and on abort, any partial
    // word is dropped so a new sequence always starts on a word boundary.
    assign pack_clear = abort || (state != ST_LOAD);
    assign pack_en    = accept && (state == ST_LOAD);

    byte_packer u_packer (
        .clk        (CLK),
        .rst_n      (RESET_N),
        .clear      (pack_clear),
        .byte_en    (pack_en),
        .byte_data  (rx_data),
        .word_valid (word_valid),
        .word       (packed_word)
    );

    assign iwr_addr = word_idx;
    assign iwr_data = SIZE'(packed_word);

    // State register.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Header capture: the low byte is held until the high byte arrives, and
    // the full count is latched on the transition out of HDR_HI.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            hdr_lo     <= 8'd0;
            word_count <= '0;
        end else if (abort) begin
            hdr_lo     <= 8'd0;
            word_count <= '0;
        end else if (accept && (state == ST_HDR_LO)) begin
            hdr_lo <= rx_data;
        end else if (accept && (state == ST_HDR_HI)) begin
            word_count <= hdr_words;
        end
    end

    // Word index advances after each write except the last, so the address
    // never wraps; it returns to 0 whenever the block leaves LOAD.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            word_idx <= '0;
        end else if (abort || (state != ST_LOAD)) begin
            word_idx <= '0;
        end else if (word_valid && !last_word) begin
            word_idx <= word_idx + 1'b1;
        end
    end

    // Run counter: counts cycles spent in RUN, starting at 0 on entry.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            run_cnt <= 32'd0;
        end else if (abort || (state != ST_RUN)) begin
            run_cnt <= 32'd0;
        end else begin
            run_cnt <= run_cnt + 32'd1;
        end
    end

    // Next-state and output decode. abort overrides everything at the end.
    always_comb begin
        next_state = state;
        iwr_en     = 1'b0;
        core_rst_n = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        error      = 1'b0;

        case (state)
            ST_IDLE: begin
                if (start) next_state = ST_HDR_LO;
            end
            ST_HDR_LO: begin
                busy = 1'b1;
                if (accept) next_state = ST_HDR_HI;
            end
            ST_HDR_HI: begin
                busy = 1'b1;
                if (accept) begin
                    if (hdr_words == '0) begin
                        next_state = ST_RUN;
                    end else if (33'(hdr_words) > CAPACITY) begin
                        next_state = ST_ERROR;
                    end else begin
                        next_state = ST_LOAD;
                    end
                end
            end
            ST_LOAD: begin
                busy = 1'b1;
                if (word_valid) begin
                    iwr_en = 1'b1;
                    if (last_word) next_state = ST_RUN;
                end
            end
            ST_RUN: begin
                busy       = 1'b1;
                core_rst_n = 1'b1;
                if (run_cnt == RUN_LAST) next_state = ST_DONE;
            end
            ST_DONE: begin
                done = 1'b1;
                if (start) next_state = ST_HDR_LO;
            end
            ST_ERROR: begin
                error = 1'b1;
                if (start) next_state = ST_HDR_LO;
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase

        if (abort) begin
            next_state = ST_IDLE;
            iwr_en     = 1'b0;
        end
    end

endmodule

// File: doc/imem_boot_ctrl.md
IMEM_BOOT_CTRL -- requirements
Module: imem_boot_ctrl

Interface
REQ-001 Parameter ADDR_WIDTH, default 10: instruction-memory word-address width; capacity 2^ADDR_WIDTH words.
REQ-002 Parameter SIZE, default 32: instruction word width; fixed at 32 (4 bytes per word).
REQ-003 Parameter RUN_CYCLES, default 1000: core clock cycles granted per run.
REQ-004 CLK  in  1  the one clock; all state on rising edge.
REQ-005 RESET_N  in  1  asynchronous, active-low reset.
REQ-006 start  in  1  single-cycle request to begin a load-and-run sequence.
REQ-007 abort  in  1  synchronous abort; returns the block to IDLE.
REQ-008 rx_valid  in  1  byte-stream valid.
REQ-009 rx_data  in  8  byte-stream payload.
REQ-010 rx_ready  out  1  byte accepted when rx_valid && rx_ready.
REQ-011 iwr_en  out  1  instruction-memory write strobe.
REQ-012 iwr_addr  out  ADDR_WIDTH  instruction-memory word address.
REQ-013 iwr_data  out  SIZE  instruction word.
REQ-014 core_rst_n  out  1  active-low reset driven to the single-cycle core.
REQ-015 busy, done, error  out  1 each  status flags.

Function
REQ-016 FSM states IDLE, HDR_LO, HDR_HI, LOAD, RUN, DONE, ERROR.
REQ-017 start in IDLE, DONE or ERROR -> HDR_LO next cycle; start in other states ignored.
REQ-018 rx_ready = 1 exactly in HDR_LO, HDR_HI, LOAD; 0 elsewhere.
REQ-019 Header: two accepted bytes, little-endian, form 16-bit word count N (HDR_LO -> HDR_HI -> next).
REQ-020 After HDR_HI: N = 0 -> RUN; N > 2^ADDR_WIDTH -> ERROR; otherwise -> LOAD.
REQ-021 LOAD: 2-bit byte counter; accepted bytes assembled little-endian (first byte = bits 7:0).
REQ-022 Cycle after 4th byte of a word is accepted: iwr_en = 1 for exactly one cycle, iwr_data = assembled word, iwr_addr = word index (0, 1, ... N-1).
REQ-023 Word index after N-1 does not wrap in LOAD; write of word N-1 moves FSM to RUN in the same cycle iwr_en is asserted.
REQ-024 rx_ready may remain high during the iwr_en cycle; bytes accepted then begin the next word.
REQ-025 RUN: core_rst_n = 1; 32-bit run counter counts RUN_CYCLES cycles, then -> DONE.
REQ-026 core_rst_n = 0 in every state except RUN.
REQ-027 busy = 1 in HDR_LO, HDR_HI, LOAD, RUN; done = 1 only in DONE; error = 1 only in ERROR.
REQ-028 abort has priority over start and all transitions: next state IDLE, counters cleared, iwr_en 0.
REQ-029 rx_valid while rx_ready = 0: no effect, no byte consumed.

Reset
REQ-030 RESET_N low: state IDLE, counters 0, iwr_en 0, iwr_addr 0, iwr_data 0, rx_ready 0, core_rst_n 0, busy/done/error 0.
REQ-031 Reset mid-LOAD or mid-RUN discards partial word and run count; no further iwr_en until a new header completes.

Structure
REQ-032 Shared package boot_pkg holds the state enum and the header byte count constant (2).
REQ-033 One sub-module natural: byte_packer (byte counter + 32-bit little-endian shift assembly, word_valid pulse).

Verification
REQ-034 Reset, start, header 0x02,0x00, bytes 0x93,0x00,0x10,0x00,0x13,0x01,0x20,0x00 -> writes 0x00100093@0, 0x00200113@1, then core_rst_n high exactly 1000 cycles, done = 1.
REQ-035 Header 0x01,0x04 (N = 1025) with ADDR_WIDTH = 10 -> ERROR, error = 1, no iwr_en, core_rst_n stays 0.
REQ-036 Header 0x00,0x00 -> RUN directly, no iwr_en; RUN_CYCLES = 5 gives core_rst_n high 5 cycles.
REQ-037 rx_valid toggled randomly with N = 3 -> exactly 3 iwr_en pulses, correct words at addresses 0..2.
REQ-038 abort after 6 load bytes -> IDLE next cycle, rx_ready 0; restart loads word 0 correctly.
REQ-039 RESET_N asserted mid-RUN -> core_rst_n 0 immediately (asynchronous), all flags 0.
